// File: rtl/cp0_exc_ctrl.sv
// Commit-stage exception/interrupt controller for CP0: prioritises exceptions, strobes
// CP0 updates, and sequences the pipeline flush and fetch redirect for exceptions and ERET.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        commit_eret,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_ld,
  input  logic        exc_ades,
  input  logic [31:0] commit_badvaddr,
  input  logic [31:0] cp0_Status_data,
  input  logic [31:0] cp0_Cause_data,
  input  logic [31:0] cp0_EPC_data,
  output logic        exception,
  output logic        bd,
  output logic [4:0]  ExcCode,
  output logic [31:0] epc_out,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_out,
  output logic        exl_clr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {StIdle, StFlush} state_e;

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        int_pending_q;
  logic        int_req;

  logic        take_exc;
  logic [4:0]  exc_code;
  logic        bv_we;
  logic [31:0] bv_val;

  logic        exception_d, bd_d, badvaddr_we_d, exl_clr_d, flush_d, redirect_valid_d;
  logic        commit_ready_d;
  logic [4:0]  exc_code_d;
  logic [31:0] epc_d, badvaddr_d, redirect_pc_d;

  logic unused_bits;
  assign unused_bits = ^{cp0_Status_data[31:16], cp0_Status_data[7:2],
                         cp0_Cause_data[31:16], cp0_Cause_data[7:0]};

  // IE set, EXL clear, and any unmasked pending interrupt line.
  assign int_req = cp0_Status_data[0] & ~cp0_Status_data[1] &
                   (|(cp0_Cause_data[15:8] & cp0_Status_data[15:8]));

  always_comb begin
    take_exc = 1'b1;
    exc_code = 5'h00;
    bv_we    = 1'b0;
    bv_val   = 32'h0;
    if (int_pending_q) begin
      exc_code = 5'h00;
    end else if (exc_adel_if) begin
      exc_code = 5'h04;
      bv_we    = 1'b1;
      bv_val   = commit_pc;
    end else if (exc_ri) begin
      exc_code = 5'h0A;
    end else if (exc_ov) begin
      exc_code = 5'h0C;
    end else if (exc_sys) begin
      exc_code = 5'h08;
    end else if (exc_bp) begin
      exc_code = 5'h09;
    end else if (exc_adel_ld) begin
      exc_code = 5'h04;
      bv_we    = 1'b1;
      bv_val   = commit_badvaddr;
    end else if (exc_ades) begin
      exc_code = 5'h05;
      bv_we    = 1'b1;
      bv_val   = commit_badvaddr;
    end else begin
      take_exc = 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    exception_d      = 1'b0;
    exl_clr_d        = 1'b0;
    badvaddr_we_d    = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    bd_d             = bd;
    exc_code_d       = ExcCode;
    epc_d            = epc_out;
    badvaddr_d       = badvaddr_out;
    redirect_pc_d    = redirect_pc;
    unique case (state_q)
      StIdle: begin
        if (commit_valid && (take_exc || commit_eret)) begin
          state_d          = StFlush;
          cnt_d            = FlushInit;
          flush_d          = 1'b1;
          redirect_valid_d = (FlushInit == 4'd1);
          if (take_exc) begin
            exception_d   = 1'b1;
            bd_d          = commit_bd;
            exc_code_d    = exc_code;
            epc_d         = commit_bd ? commit_pc - 32'd4 : commit_pc;
            badvaddr_we_d = bv_we;
            if (bv_we) badvaddr_d = bv_val;
            redirect_pc_d = EXC_VECTOR;
          end else begin
            exl_clr_d     = 1'b1;
            redirect_pc_d = cp0_EPC_data;
          end
        end
      end
      StFlush: begin
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d            = cnt_q - 4'd1;
          flush_d          = 1'b1;
          // Redirect lands in the last flush cycle.
          redirect_valid_d = (cnt_q == 4'd2);
        end
      end
      default: state_d = StIdle;
    endcase
    commit_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      int_pending_q  <= 1'b0;
      exception      <= 1'b0;
      bd             <= 1'b0;
      ExcCode        <= 5'h00;
      epc_out        <= 32'h0;
      badvaddr_we    <= 1'b0;
      badvaddr_out   <= 32'h0;
      exl_clr        <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      commit_ready   <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      int_pending_q  <= int_req;
      exception      <= exception_d;
      bd             <= bd_d;
      ExcCode        <= exc_code_d;
      epc_out        <= epc_d;
      badvaddr_we    <= badvaddr_we_d;
      badvaddr_out   <= badvaddr_d;
      exl_clr        <= exl_clr_d;
      flush          <= flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      commit_ready   <= commit_ready_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with FLUSH_CYCLES = 2 and hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, commit_ready, commit_bd, commit_eret;
  logic [31:0] commit_pc, commit_badvaddr;
  logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades;
  logic [31:0] cp0_Status_data, cp0_Cause_data, cp0_EPC_data;
  logic        exception, bd, badvaddr_we, exl_clr, flush, redirect_valid;
  logic [4:0]  ExcCode;
  logic [31:0] epc_out, badvaddr_out, redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(
    .EXC_VECTOR  (32'hBFC0_0380),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .commit_pc      (commit_pc),
    .commit_bd      (commit_bd),
    .commit_eret    (commit_eret),
    .exc_adel_if    (exc_adel_if),
    .exc_ri         (exc_ri),
    .exc_ov         (exc_ov),
    .exc_sys        (exc_sys),
    .exc_bp         (exc_bp),
    .exc_adel_ld    (exc_adel_ld),
    .exc_ades       (exc_ades),
    .commit_badvaddr(commit_badvaddr),
    .cp0_Status_data(cp0_Status_data),
    .cp0_Cause_data (cp0_Cause_data),
    .cp0_EPC_data   (cp0_EPC_data),
    .exception      (exception),
    .bd             (bd),
    .ExcCode        (ExcCode),
    .epc_out        (epc_out),
    .badvaddr_we    (badvaddr_we),
    .badvaddr_out   (badvaddr_out),
    .exl_clr        (exl_clr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades} = 7'b0;
    commit_eret = 1'b0;
  endtask

  // flags = {adel_if, ri, ov, sys, bp, adel_ld, ades}; returns #1 after the T+1 edge.
  task automatic do_commit(input logic [31:0] pc, input logic bdi, input logic eret,
                           input logic [6:0] flags, input logic [31:0] badv, input logic keep);
    @(negedge clk);
    commit_valid    = 1'b1;
    commit_pc       = pc;
    commit_bd       = bdi;
    commit_eret     = eret;
    commit_badvaddr = badv;
    {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades} = flags;
    @(posedge clk);
    #1;
    if (!keep) begin
      commit_valid = 1'b0;
      clear_flags();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    commit_valid = 1'b0;
    commit_pc = 32'h0;
    commit_bd = 1'b0;
    commit_badvaddr = 32'h0;
    clear_flags();
    cp0_Status_data = 32'h0;
    cp0_Cause_data  = 32'h0;
    cp0_EPC_data    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst exception", {31'b0, exception}, 32'd0);
    check("rst flush", {31'b0, flush}, 32'd0);
    check("rst ExcCode", {27'b0, ExcCode}, 32'd0);
    check("rst epc_out", epc_out, 32'h0);
    check("rst redirect_pc", redirect_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ready after reset", {31'b0, commit_ready}, 32'd1);

    // Ov, no delay slot
    do_commit(32'h8000_1000, 1'b0, 1'b0, 7'b0010000, 32'h0, 1'b0);
    check("ov exception", {31'b0, exception}, 32'd1);
    check("ov ExcCode", {27'b0, ExcCode}, 32'h0C);
    check("ov epc", epc_out, 32'h8000_1000);
    check("ov bd", {31'b0, bd}, 32'd0);
    check("ov badvaddr_we", {31'b0, badvaddr_we}, 32'd0);
    check("ov flush T1", {31'b0, flush}, 32'd1);
    check("ov redirect T1", {31'b0, redirect_valid}, 32'd0);
    check("ov ready T1", {31'b0, commit_ready}, 32'd0);
    step();
    check("ov exception T2", {31'b0, exception}, 32'd0);
    check("ov flush T2", {31'b0, flush}, 32'd1);
    check("ov redirect T2", {31'b0, redirect_valid}, 32'd1);
    check("ov redirect_pc", redirect_pc, 32'hBFC0_0380);
    step();
    check("ov flush T3", {31'b0, flush}, 32'd0);
    check("ov redirect T3", {31'b0, redirect_valid}, 32'd0);
    check("ov ready T3", {31'b0, commit_ready}, 32'd1);

    // AdES in a delay slot
    do_commit(32'h8000_2004, 1'b1, 1'b0, 7'b0000001, 32'h1234_5671, 1'b0);
    check("ades bd", {31'b0, bd}, 32'd1);
    check("ades epc", epc_out, 32'h8000_2000);
    check("ades ExcCode", {27'b0, ExcCode}, 32'h05);
    check("ades badvaddr_we", {31'b0, badvaddr_we}, 32'd1);
    check("ades badvaddr", badvaddr_out, 32'h1234_5671);
    step();
    check("ades badvaddr_we T2", {31'b0, badvaddr_we}, 32'd0);
    step();

    // Interrupt beats RI when enabled
    @(negedge clk);
    cp0_Status_data = 32'h0000_8001;
    cp0_Cause_data  = 32'h0000_8000;
    do_commit(32'h8000_0100, 1'b0, 1'b0, 7'b0100000, 32'h0, 1'b0);
    check("int exception", {31'b0, exception}, 32'd1);
    check("int ExcCode", {27'b0, ExcCode}, 32'h00);
    step();
    step();
    @(negedge clk);
    cp0_Status_data = 32'h0000_8003;
    do_commit(32'h8000_0104, 1'b0, 1'b0, 7'b0100000, 32'h0, 1'b0);
    check("exl ri exception", {31'b0, exception}, 32'd1);
    check("exl ri ExcCode", {27'b0, ExcCode}, 32'h0A);
    step();
    step();
    @(negedge clk);
    cp0_Status_data = 32'h0;
    cp0_Cause_data  = 32'h0;
    step();

    // Ordinary commit
    do_commit(32'h8000_0200, 1'b0, 1'b0, 7'b0, 32'h0, 1'b0);
    check("plain exception", {31'b0, exception}, 32'd0);
    check("plain flush", {31'b0, flush}, 32'd0);
    check("plain ready", {31'b0, commit_ready}, 32'd1);

    // ERET
    cp0_EPC_data = 32'h8000_3000;
    do_commit(32'h8000_0300, 1'b0, 1'b1, 7'b0, 32'h0, 1'b0);
    check("eret exl_clr", {31'b0, exl_clr}, 32'd1);
    check("eret exception", {31'b0, exception}, 32'd0);
    check("eret flush", {31'b0, flush}, 32'd1);
    step();
    check("eret exl_clr T2", {31'b0, exl_clr}, 32'd0);
    check("eret redirect", {31'b0, redirect_valid}, 32'd1);
    check("eret redirect_pc", redirect_pc, 32'h8000_3000);
    step();

    // ERET with AdEL on fetch
    do_commit(32'h8000_4001, 1'b0, 1'b1, 7'b1000000, 32'hDEAD_BEEF, 1'b0);
    check("eret+adel exception", {31'b0, exception}, 32'd1);
    check("eret+adel exl_clr", {31'b0, exl_clr}, 32'd0);
    check("eret+adel ExcCode", {27'b0, ExcCode}, 32'h04);
    check("eret+adel badvaddr", badvaddr_out, 32'h8000_4001);
    step();
    check("eret+adel redirect_pc", redirect_pc, 32'hBFC0_0380);
    step();

    // commit_valid held during FLUSH is ignored
    do_commit(32'h8000_5000, 1'b0, 1'b0, 7'b0001000, 32'h0, 1'b1);
    check("hold exception T1", {31'b0, exception}, 32'd1);
    check("hold ExcCode", {27'b0, ExcCode}, 32'h08);
    check("hold ready T1", {31'b0, commit_ready}, 32'd0);
    step();
    check("hold exception T2", {31'b0, exception}, 32'd0);
    check("hold ready T2", {31'b0, commit_ready}, 32'd0);
    commit_valid = 1'b0;
    clear_flags();
    step();
    check("hold exception T3", {31'b0, exception}, 32'd0);
    check("hold ready T3", {31'b0, commit_ready}, 32'd1);

    // Reset during FLUSH drops the redirect
    do_commit(32'h8000_6000, 1'b0, 1'b0, 7'b0000100, 32'h0, 1'b0);
    check("rstmid exception", {31'b0, exception}, 32'd1);
    rst_n = 1'b0;
    step();
    check("rstmid flush", {31'b0, flush}, 32'd0);
    check("rstmid redirect", {31'b0, redirect_valid}, 32'd0);
    check("rstmid redirect_pc", redirect_pc, 32'h0);
    check("rstmid ready", {31'b0, commit_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid no redirect", {31'b0, redirect_valid | flush}, 32'd0);
    end

    // EPC wrap-around in delay slot at PC 0
    do_commit(32'h0000_0000, 1'b1, 1'b0, 7'b0001000, 32'h0, 1'b0);
    check("wrap epc", epc_out, 32'hFFFF_FFFC);
    check("wrap bd", {31'b0, bd}, 32'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
